// File: rtl/cpu_types_pkg.sv
// Shared processor datapath types: RAM status, machine word and the memory
// arbiter state encoding.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_starve_ctr.sv
// Counts data completions that overtook a waiting instruction fetch; only
// compiled when MEMARB_FAIR_EN is defined.
`ifdef MEMARB_FAIR_EN
module mem_arbiter_starve_ctr #(
    parameter int LIMIT = 4,
    parameter int CW    = $clog2(LIMIT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          data_done,
    input  logic          instr_done,
    input  logic          instr_req,
    output logic [CW-1:0] count
);

    // Saturates at LIMIT in case the fetch request appears mid data grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (instr_done) begin
            count <= '0;
        end else if (data_done) begin
            if (!instr_req) begin
                count <= '0;
            end else if (count != CW'(LIMIT)) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Shares the single RAM port between the I-cache and D-cache, data first.
// Define MEMARB_FAIR_EN to bound instruction starvation to FAIR_LIMIT grants.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FAIR_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    arb_state_t state, next_state;
    ramstate_t  ram_st;
    logic       d_req;
    logic       d_done;
    logic       i_done;
    logic       fair_force_i;

    assign ram_st = ramstate_t'(ramstate);
    assign d_req  = dREN | dWEN;
    assign d_done = !RST && (state == DGRANT) && d_req && (ram_st == ACCESS);
    assign i_done = !RST && (state == IGRANT) && iREN && (ram_st == ACCESS);
    assign iload  = ramload;
    assign dload  = ramload;

`ifdef MEMARB_FAIR_EN
    localparam int CW = $clog2(FAIR_LIMIT + 1);
    logic [CW-1:0] starve_count;

    mem_arbiter_starve_ctr #(
        .LIMIT (FAIR_LIMIT),
        .CW    (CW)
    ) u_starve_ctr (
        .clk        (CLK),
        .rst        (RST),
        .data_done  (d_done),
        .instr_done (i_done),
        .instr_req  (iREN),
        .count      (starve_count)
    );

    assign fair_force_i = iREN && (starve_count == CW'(FAIR_LIMIT));
`else
    logic unused_fair;
    assign fair_force_i = 1'b0;
    assign unused_fair  = ^FAIR_LIMIT;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Reset forces the idle output set even while a grant is still registered.
    always_comb begin
        next_state = state;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = 1'b1;
        dwait      = 1'b1;
        if (RST) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (fair_force_i) begin
                        next_state = IGRANT;
                    end else if (d_req) begin
                        next_state = DGRANT;
                    end else if (iREN) begin
                        next_state = IGRANT;
                    end
                end
                DGRANT: begin
                    ramaddr  = daddr;
                    ramstore = dstore;
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    if (!d_req) begin
                        next_state = IDLE;
                    end else if (ram_st == ACCESS) begin
                        dwait      = 1'b0;
                        next_state = IDLE;
                    end
                end
                IGRANT: begin
                    ramaddr = iaddr;
                    ramREN  = iREN;
                    if (!iREN) begin
                        next_state = IDLE;
                    end else if (ram_st == ACCESS) begin
                        iwait      = 1'b0;
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic, compared against a transaction-level ownership model.
module tb_mem_arbiter;

    localparam int FAIR_LIMIT = 4;
    localparam int OWN_NONE   = 0;
    localparam int OWN_DATA   = 1;
    localparam int OWN_INSTR  = 2;

    logic        CLK = 1'b0;
    logic        RST, iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        iwait, dwait, ramREN, ramWEN;

    int checks   = 0;
    int failures = 0;
    int owner    = OWN_NONE;
    int starve   = 0;

    mem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .FAIR_LIMIT (FAIR_LIMIT)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .iwait    (iwait),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dload    (dload),
        .dwait    (dwait),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drives one cycle, checks outputs mid-cycle, then advances the model.
    task automatic applyStimulus(input logic rst, input logic iren, input logic dren,
                                 input logic dwen, input logic [1:0] rs,
                                 input logic [31:0] ia, input logic [31:0] da,
                                 input logic [31:0] ds, input logic [31:0] rl);
        logic        expRen, expWen, expIw, expDw;
        logic [31:0] expAddr, expStore;
        bit          dataDone, instrDone;
        int          nextOwner;
        RST = rst; iREN = iren; dREN = dren; dWEN = dwen; ramstate = rs;
        iaddr = ia; daddr = da; dstore = ds; ramload = rl;
        expRen = 1'b0; expWen = 1'b0; expIw = 1'b1; expDw = 1'b1;
        expAddr = '0; expStore = '0; dataDone = 0; instrDone = 0;
        nextOwner = owner;
        if (rst) begin
            nextOwner = OWN_NONE;
        end else if (owner == OWN_DATA) begin
            expAddr = da; expStore = ds;
            expWen = dwen; expRen = dren && !dwen;
            if (!(dren || dwen)) nextOwner = OWN_NONE;
            else if (rs == 2'd2) begin
                expDw = 1'b0; dataDone = 1; nextOwner = OWN_NONE;
            end
        end else if (owner == OWN_INSTR) begin
            expAddr = ia; expRen = iren;
            if (!iren) nextOwner = OWN_NONE;
            else if (rs == 2'd2) begin
                expIw = 1'b0; instrDone = 1; nextOwner = OWN_NONE;
            end
        end else begin
`ifdef MEMARB_FAIR_EN
            if (iren && starve == FAIR_LIMIT) nextOwner = OWN_INSTR;
            else
`endif
            if (dren || dwen) nextOwner = OWN_DATA;
            else if (iren) nextOwner = OWN_INSTR;
        end
        @(negedge CLK);
        checkOutput("ramREN", 64'(ramREN), 64'(expRen));
        checkOutput("ramWEN", 64'(ramWEN), 64'(expWen));
        checkOutput("ramaddr", 64'(ramaddr), 64'(expAddr));
        checkOutput("ramstore", 64'(ramstore), 64'(expStore));
        checkOutput("iwait", 64'(iwait), 64'(expIw));
        checkOutput("dwait", 64'(dwait), 64'(expDw));
        checkOutput("iload", 64'(iload), 64'(rl));
        checkOutput("dload", 64'(dload), 64'(rl));
        @(posedge CLK);
        owner = nextOwner;
        if (rst || instrDone) starve = 0;
        else if (dataDone) starve = iren ? ((starve < FAIR_LIMIT) ? starve + 1 : starve) : 0;
        #1;
    endtask

    initial begin
        logic        ri, rd, rw;
        logic [1:0]  rs;
        RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = 2'd0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
        @(posedge CLK); #1;

        applyStimulus(1, 0, 0, 0, 2'd0, 0, 0, 0, 32'h0);
        applyStimulus(1, 0, 0, 0, 2'd0, 0, 0, 0, 32'h0);

        // Instruction fetch: ACCESS on the third grant cycle, then a bubble.
        applyStimulus(0, 1, 0, 0, 2'd0, 32'h40, 0, 0, 32'h0);
        applyStimulus(0, 1, 0, 0, 2'd1, 32'h40, 0, 0, 32'h0);
        applyStimulus(0, 1, 0, 0, 2'd1, 32'h40, 0, 0, 32'h0);
        applyStimulus(0, 1, 0, 0, 2'd2, 32'h40, 0, 0, 32'h8C220004);
        applyStimulus(0, 0, 0, 0, 2'd0, 32'h40, 0, 0, 32'h0);

        // Simultaneous requests: data store first, fetch after one bubble.
        applyStimulus(0, 1, 0, 1, 2'd0, 32'h44, 32'h100, 32'hDEADBEEF, 32'h0);
        applyStimulus(0, 1, 0, 1, 2'd2, 32'h44, 32'h100, 32'hDEADBEEF, 32'h0);
        applyStimulus(0, 1, 0, 0, 2'd0, 32'h44, 32'h100, 32'hDEADBEEF, 32'h0);
        applyStimulus(0, 1, 0, 0, 2'd2, 32'h44, 32'h0, 32'h0, 32'h12345678);
        applyStimulus(0, 0, 0, 0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);

        // Read and write together: write wins.
        applyStimulus(0, 0, 1, 1, 2'd0, 0, 32'h200, 32'hA5A5A5A5, 32'h0);
        applyStimulus(0, 0, 1, 1, 2'd1, 0, 32'h200, 32'hA5A5A5A5, 32'h0);
        applyStimulus(0, 0, 1, 1, 2'd2, 0, 32'h200, 32'hA5A5A5A5, 32'h0);
        applyStimulus(0, 0, 0, 0, 2'd0, 0, 0, 0, 32'h0);

        // ERROR retried five times before ACCESS.
        applyStimulus(0, 0, 1, 0, 2'd0, 0, 32'h300, 0, 32'h0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0, 2'd3, 0, 32'h300, 0, 32'h0);
        applyStimulus(0, 0, 1, 0, 2'd2, 0, 32'h300, 0, 32'hCAFEF00D);
        applyStimulus(0, 0, 0, 0, 2'd0, 0, 0, 0, 32'h0);

        // Abort while BUSY.
        applyStimulus(0, 0, 1, 0, 2'd0, 0, 32'h310, 0, 32'h0);
        applyStimulus(0, 0, 1, 0, 2'd1, 0, 32'h310, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 2'd1, 0, 32'h310, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 2'd2, 0, 32'h310, 0, 32'h0);

        // Reset in the middle of a data write grant.
        applyStimulus(0, 0, 0, 1, 2'd0, 0, 32'h400, 32'h11112222, 32'h0);
        applyStimulus(0, 0, 0, 1, 2'd1, 0, 32'h400, 32'h11112222, 32'h0);
        applyStimulus(1, 0, 0, 1, 2'd1, 0, 32'h400, 32'h11112222, 32'h0);
        applyStimulus(1, 0, 0, 1, 2'd1, 0, 32'h400, 32'h11112222, 32'h0);
        applyStimulus(0, 0, 0, 0, 2'd1, 0, 32'h400, 32'h11112222, 32'h0);

`ifdef MEMARB_FAIR_EN
        // Saturating traffic with single-cycle RAM exercises the fairness limit.
        for (int i = 0; i < 40; i++)
            applyStimulus(0, 1, 1, 0, 2'd2, 32'h500, 32'h600, 0, $urandom);
`endif

        ri = 0; rd = 0; rw = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 25) ri = ~ri;
            if ($urandom_range(0, 99) < 25) rd = ~rd;
            if ($urandom_range(0, 99) < 20) rw = ~rw;
            rs = 2'($urandom_range(0, 3));
            applyStimulus(($urandom_range(0, 99) < 2), ri, rd, rw, rs,
                          $urandom, $urandom, $urandom, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
